// File: rtl/uv_dev_sram_pkg.sv
// Shared definitions for the devbus SRAM device family.
//   - response exception codes
//   - clog2 helper usable in constant (parameter) expressions
package uv_dev_sram_pkg;

  localparam logic [1:0] UV_SRAM_EXCP_OK    = 2'b00;
  localparam logic [1:0] UV_SRAM_EXCP_FAULT = 2'b10;

  // Ceiling log2; clog2(0) = clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uv_dev_sram_mb_if.sv
// Devbus request/response bundle for the SRAM device.
//   master: drives requests and sram_rsp_rdy
//   slave : drives sram_req_rdy and the response channel
interface uv_dev_sram_mb_if #(
  parameter int unsigned ALEN = 32,
  parameter int unsigned DLEN = 32,
  parameter int unsigned MLEN = DLEN / 8
);
  logic            sram_req_vld;
  logic            sram_req_rdy;
  logic            sram_req_read;
  logic [ALEN-1:0] sram_req_addr;
  logic [MLEN-1:0] sram_req_mask;
  logic [DLEN-1:0] sram_req_data;
  logic            sram_rsp_vld;
  logic            sram_rsp_rdy;
  logic [1:0]      sram_rsp_excp;
  logic [DLEN-1:0] sram_rsp_data;

  modport master (
    output sram_req_vld, sram_req_read, sram_req_addr, sram_req_mask, sram_req_data,
    output sram_rsp_rdy,
    input  sram_req_rdy, sram_rsp_vld, sram_rsp_excp, sram_rsp_data
  );

  modport slave (
    input  sram_req_vld, sram_req_read, sram_req_addr, sram_req_mask, sram_req_data,
    input  sram_rsp_rdy,
    output sram_req_rdy, sram_rsp_vld, sram_rsp_excp, sram_rsp_data
  );
endinterface

// File: rtl/uv_dev_sram_rsp_fifo.sv
// First-word-fall-through response FIFO.
//   i_push/i_data : enqueue one entry ({excp, data})
//   o_vld/i_rdy   : head handshake; o_data is the head entry
//   o_cnt         : stored occupancy (registered)
// When empty, a push is presented at the head in the same cycle; if it is
// also taken that cycle it is never stored. Head is 0 when nothing is valid.
module uv_dev_sram_rsp_fifo
  import uv_dev_sram_pkg::*;
#(
  parameter int unsigned DW = 34,
  parameter int unsigned DP = 4,
  localparam int unsigned CW = clog2(DP + 1),
  localparam int unsigned PW = (DP > 1) ? clog2(DP) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  output logic          o_vld,
  input  logic          i_rdy,
  output logic [DW-1:0] o_data,
  output logic [CW-1:0] o_cnt
);
  logic [DW-1:0] r_mem [DP];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;

  logic w_empty;
  logic w_pop;
  logic w_wr;
  logic w_rd;

  assign w_empty = (r_cnt == '0);
  assign o_vld   = ~w_empty | i_push;
  assign o_data  = ~w_empty ? r_mem[r_rptr] : (i_push ? i_data : '0);
  assign w_pop   = o_vld & i_rdy;
  // A push consumed straight through an empty FIFO is not stored.
  assign w_wr    = i_push & ~(w_empty & w_pop);
  assign w_rd    = w_pop & ~w_empty;
  assign o_cnt   = r_cnt;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) r_wptr <= (r_wptr == PW'(DP - 1)) ? '0 : r_wptr + 1'b1;
      if (w_rd) r_rptr <= (r_rptr == PW'(DP - 1)) ? '0 : r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/uv_sram_sp.sv
// Single-port SRAM simulation model with byte write enables.
//   i_ce/i_we   : access enable / write enable (write when both high)
//   i_addr      : row address
//   i_wm        : byte write mask
//   i_wdata     : write data
//   o_rdata     : read data, valid 1+DLY cycles after a read access
// Contents are not reset.
module uv_sram_sp #(
  parameter int unsigned AW  = 10,
  parameter int unsigned DW  = 32,
  parameter int unsigned MW  = DW / 8,
  parameter int unsigned DLY = 0
) (
  input  logic          clk,
  input  logic          i_ce,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [MW-1:0] i_wm,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem  [2**AW];
  logic [DW-1:0] r_pipe [DLY+1];

  always_ff @(posedge clk) begin
    if (i_ce) begin
      if (i_we) begin
        for (int unsigned i = 0; i < MW; i++) begin
          if (i_wm[i]) r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
        end
      end else begin
        r_pipe[0] <= r_mem[i_addr];
      end
    end
    for (int unsigned i = 1; i <= DLY; i++) begin
      r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_rdata = r_pipe[DLY];
endmodule

// File: rtl/uv_dev_sram_mb.sv
// Multi-bank pipelined devbus SRAM slave.
//   clk, rst : clock, synchronous active-high reset
//   bus      : devbus slave (request channel in, response channel out)
// Requests are word-interleaved over NBANK single-port banks. A slot
// (valid/read/fault/bank) travels a 1+RAM_DLY shift register alongside the
// bank read pipeline and lands in a response FIFO. Request ready is issued
// only when every in-flight slot is guaranteed FIFO space, so response
// backpressure never stalls a bank.
module uv_dev_sram_mb
  import uv_dev_sram_pkg::*;
#(
  parameter int unsigned ALEN        = 32,
  parameter int unsigned DLEN        = 32,
  parameter int unsigned MLEN        = DLEN / 8,
  parameter int unsigned NBANK       = 4,
  parameter int unsigned SRAM_AW     = 10,
  parameter int unsigned RAM_DLY     = 0,
  parameter int unsigned RSP_FIFO_DP = 4
) (
  input  logic              clk,
  input  logic              rst,
  uv_dev_sram_mb_if.slave   bus
);
  localparam int unsigned OFS = clog2(MLEN);
  localparam int unsigned BW  = clog2(NBANK);
  localparam int unsigned BSW = (BW == 0) ? 1 : BW;
  localparam int unsigned WW  = ALEN - OFS;
  localparam int unsigned L   = 1 + RAM_DLY;
  localparam int unsigned IW  = clog2(L + 1);
  localparam int unsigned CW  = clog2(RSP_FIFO_DP + 1);
  localparam int unsigned SW  = CW + 1;

  if (RSP_FIFO_DP < RAM_DLY + 2) begin : g_chk_dp
    $error("uv_dev_sram_mb: RSP_FIFO_DP must be at least RAM_DLY+2");
  end
  if (RAM_DLY > 3) begin : g_chk_dly
    $error("uv_dev_sram_mb: RAM_DLY must be 0..3");
  end
  if ((NBANK == 0) || ((NBANK & (NBANK - 1)) != 0)) begin : g_chk_nbank
    $error("uv_dev_sram_mb: NBANK must be a power of two");
  end
  if ((DLEN < 8) || ((DLEN & (DLEN - 1)) != 0)) begin : g_chk_dlen
    $error("uv_dev_sram_mb: DLEN must be a power of two, at least 8");
  end
  if (WW < BW + SRAM_AW) begin : g_chk_alen
    $error("uv_dev_sram_mb: ALEN too narrow for NBANK and SRAM_AW");
  end

  typedef struct packed {
    logic           vld;
    logic           rd;
    logic           flt;
    logic [BSW-1:0] bank;
  } slot_t;

  slot_t          r_slot [L];
  logic           r_rst_q;

  logic [WW-1:0]      w_widx;
  logic [BSW-1:0]     w_bank;
  logic [SRAM_AW-1:0] w_row;
  logic               w_fault;
  logic               w_acc;
  logic               w_rdy;
  logic [NBANK-1:0]   w_ce;
  logic [DLEN-1:0]    w_rdata [NBANK];
  logic [IW-1:0]      w_inflight;
  logic [SW-1:0]      w_credit;
  logic [CW-1:0]      w_fifo_cnt;
  slot_t              w_last;
  logic               w_push;
  logic [1:0]         w_pexcp;
  logic [DLEN-1:0]    w_pdata;

  // Address decode
  assign w_widx = bus.sram_req_addr[ALEN-1:OFS];
  assign w_row  = w_widx[BW +: SRAM_AW];

  if (BW == 0) begin : g_bank_one
    assign w_bank = '0;
  end else begin : g_bank_sel
    assign w_bank = w_widx[BW-1:0];
  end

  if (WW > BW + SRAM_AW) begin : g_fault
    assign w_fault = |w_widx[WW-1:BW+SRAM_AW];
  end else begin : g_nofault
    assign w_fault = 1'b0;
  end

  // Credit: every accepted request owns one FIFO entry until it is popped.
  always_comb begin
    w_inflight = '0;
    for (int unsigned i = 0; i < L; i++) begin
      w_inflight = w_inflight + IW'(r_slot[i].vld);
    end
  end

  assign w_credit = SW'(w_inflight) + SW'(w_fifo_cnt);
  assign w_rdy    = ~rst & ~r_rst_q & (w_credit < SW'(RSP_FIFO_DP));
  assign w_acc    = bus.sram_req_vld & w_rdy;
  assign bus.sram_req_rdy = w_rdy;

  // Banks
  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    assign w_ce[b] = w_acc & ~w_fault & (w_bank == BSW'(b));
`ifdef UV_SRAM_ASIC
    uv_sram_asic_macro #(.AW(SRAM_AW), .DW(DLEN), .MW(MLEN), .DLY(RAM_DLY)) u_ram (
`elsif UV_SRAM_FPGA
    uv_sram_fpga_macro #(.AW(SRAM_AW), .DW(DLEN), .MW(MLEN), .DLY(RAM_DLY)) u_ram (
`else
    uv_sram_sp #(.AW(SRAM_AW), .DW(DLEN), .MW(MLEN), .DLY(RAM_DLY)) u_ram (
`endif
      .clk     (clk),
      .i_ce    (w_ce[b]),
      .i_we    (~bus.sram_req_read),
      .i_addr  (w_row),
      .i_wm    (bus.sram_req_mask),
      .i_wdata (bus.sram_req_data),
      .o_rdata (w_rdata[b])
    );
  end

  // Response slot pipeline, aligned with the bank read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rst_q <= 1'b1;
      for (int unsigned i = 0; i < L; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      r_rst_q        <= 1'b0;
      r_slot[0].vld  <= w_acc;
      r_slot[0].rd   <= bus.sram_req_read;
      r_slot[0].flt  <= w_fault;
      r_slot[0].bank <= w_bank;
      for (int unsigned i = 1; i < L; i++) begin
        r_slot[i] <= r_slot[i-1];
      end
    end
  end

  assign w_last  = r_slot[L-1];
  assign w_push  = w_last.vld;
  assign w_pexcp = w_last.flt ? UV_SRAM_EXCP_FAULT : UV_SRAM_EXCP_OK;
  assign w_pdata = (w_last.vld & w_last.rd & ~w_last.flt) ? w_rdata[w_last.bank] : '0;

  uv_dev_sram_rsp_fifo #(
    .DW (2 + DLEN),
    .DP (RSP_FIFO_DP)
  ) u_rsp_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_data ({w_pexcp, w_pdata}),
    .o_vld  (bus.sram_rsp_vld),
    .i_rdy  (bus.sram_rsp_rdy),
    .o_data ({bus.sram_rsp_excp, bus.sram_rsp_data}),
    .o_cnt  (w_fifo_cnt)
  );
endmodule

// File: tb/tb_uv_dev_sram_mb.sv
module tb_uv_dev_sram_mb;
  localparam int unsigned DLY = 2;
  localparam int unsigned DP  = 4;
  localparam int unsigned NB  = 4;
  localparam int unsigned AW  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uv_dev_sram_mb_if #(.ALEN(32), .DLEN(32), .MLEN(4)) bus  ();
  uv_dev_sram_mb_if #(.ALEN(32), .DLEN(32), .MLEN(4)) bus0 ();

  uv_dev_sram_mb #(
    .ALEN(32), .DLEN(32), .MLEN(4), .NBANK(NB), .SRAM_AW(AW),
    .RAM_DLY(DLY), .RSP_FIFO_DP(DP)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  uv_dev_sram_mb #(
    .ALEN(32), .DLEN(32), .MLEN(4), .NBANK(NB), .SRAM_AW(AW),
    .RAM_DLY(0), .RSP_FIFO_DP(DP)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  typedef struct {
    logic [1:0]  excp;
    logic [31:0] data;
    bit          lat;
    int unsigned acyc;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] model [int unsigned];
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  bit          chk_lat = 0;
  int          waits = 0;
  int          ovf = 0;
  logic [3:0]  last_ce;
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: a handshake seen at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!rst && bus.sram_rsp_vld && bus.sram_rsp_rdy) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected got excp=%b data=%h, required no response",
                 bus.sram_rsp_excp, bus.sram_rsp_data);
      end else begin
        mon_e = sbq.pop_front();
        if (bus.sram_rsp_excp !== mon_e.excp || bus.sram_rsp_data !== mon_e.data) begin
          fails++;
          $display("FAIL rsp_data got excp=%b data=%h, required excp=%b data=%h",
                   bus.sram_rsp_excp, bus.sram_rsp_data, mon_e.excp, mon_e.data);
        end
        if (mon_e.lat) begin
          tests++;
          if ((cyc - mon_e.acyc) !== 1 + DLY) begin
            fails++;
            $display("FAIL rsp_latency got %0d, required %0d", cyc - mon_e.acyc, 1 + DLY);
          end
        end
      end
    end
    if (!rst && dut.w_push && (dut.w_fifo_cnt == DP) && !(bus.sram_rsp_vld && bus.sram_rsp_rdy))
      ovf++;
  end

  task automatic push_exp(input bit rd, input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] data);
    exp_t e;
    int unsigned w;
    logic [31:0] v;
    w = addr >> 2;
    e.lat  = chk_lat;
    e.acyc = cyc;
    if (w >= (NB << AW)) begin
      e.excp = 2'b10;
      e.data = '0;
    end else if (rd) begin
      e.excp = 2'b00;
      e.data = model.exists(w) ? model[w] : 'x;
    end else begin
      v = model.exists(w) ? model[w] : '0;
      for (int b = 0; b < 4; b++) if (mask[b]) v[b*8 +: 8] = data[b*8 +: 8];
      model[w] = v;
      e.excp = 2'b00;
      e.data = '0;
    end
    sbq.push_back(e);
  endtask

  // Starts and ends at posedge+1.
  task automatic do_req(input bit rd, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data);
    bit done;
    done = 0;
    bus.sram_req_vld  = 1'b1;
    bus.sram_req_read = rd;
    bus.sram_req_addr = addr;
    bus.sram_req_mask = mask;
    bus.sram_req_data = data;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.sram_req_rdy) begin
        push_exp(rd, addr, mask, data);
        last_ce = dut.w_ce;
        done = 1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    bus.sram_req_vld = 1'b0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL req_timeout addr=%h got no accept, required accept within 100 cycles", addr);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && sbq.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending, required 0", sbq.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    tests++;
    if (bus.sram_req_rdy !== 1'b0) begin
      fails++; $display("FAIL reset_rdy_during got %b, required 0", bus.sram_req_rdy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests += 4;
    if (bus.sram_req_rdy !== 1'b0) begin
      fails++; $display("FAIL reset_rdy_after1 got %b, required 0", bus.sram_req_rdy);
    end
    if (bus.sram_rsp_vld !== 1'b0) begin
      fails++; $display("FAIL reset_vld got %b, required 0", bus.sram_rsp_vld);
    end
    if (bus.sram_rsp_excp !== 2'b00) begin
      fails++; $display("FAIL reset_excp got %b, required 00", bus.sram_rsp_excp);
    end
    if (bus.sram_rsp_data !== 32'h0) begin
      fails++; $display("FAIL reset_data got %h, required 0", bus.sram_rsp_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (bus.sram_req_rdy !== 1'b1) begin
      fails++; $display("FAIL reset_rdy_after2 got %b, required 1", bus.sram_req_rdy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    chk_lat = 1;
    do_req(0, 32'h10, 4'hF, 32'hDEADBEEF);
    do_req(1, 32'h10, 4'h0, 32'h0);
    chk_lat = 0;
    wait_drain();
  endtask

  task automatic test_mask();
    chk_lat = 1;
    do_req(0, 32'h0, 4'hF, 32'h11223344);
    do_req(0, 32'h0, 4'b0101, 32'hAABBCCDD);
    do_req(1, 32'h0, 4'h0, 32'h0);
    do_req(0, 32'h0, 4'h0, 32'hFFFFFFFF);
    do_req(1, 32'h0, 4'h0, 32'h0);
    chk_lat = 0;
    wait_drain();
  endtask

  task automatic test_stream();
    chk_lat = 1;
    waits = 0;
    for (int i = 0; i < 64; i++) do_req(0, 32'(i * 4), 4'hF, $urandom);
    for (int i = 0; i < 64; i++) do_req(1, 32'(i * 4), 4'h0, 32'h0);
    tests++;
    if (waits != 0) begin
      fails++; $display("FAIL stream_rdy_drop got %0d stalls, required 0", waits);
    end
    chk_lat = 0;
    wait_drain();
  endtask

  task automatic test_backpressure();
    int acc;
    int acc_hold;
    int first_after;
    acc = 0;
    acc_hold = -1;
    first_after = -1;
    bus.sram_rsp_rdy = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (k == 12) begin
        bus.sram_rsp_rdy = 1'b1;
        acc_hold = acc;
      end
      bus.sram_req_vld  = 1'b1;
      bus.sram_req_read = 1'b1;
      bus.sram_req_addr = 32'(acc * 4);
      bus.sram_req_mask = 4'h0;
      bus.sram_req_data = 32'h0;
      @(negedge clk);
      if (k == 12) begin
        tests++;
        if (bus.sram_req_rdy !== 1'b0) begin
          fails++; $display("FAIL bp_rdy_release got %b, required 0", bus.sram_req_rdy);
        end
      end
      if (bus.sram_req_rdy) begin
        push_exp(1, 32'(acc * 4), 4'h0, 32'h0);
        acc++;
        if (k >= 12 && first_after < 0) first_after = k;
      end
      @(posedge clk); #1;
    end
    bus.sram_req_vld = 1'b0;
    tests += 2;
    if (acc_hold != DP) begin
      fails++; $display("FAIL bp_accepted got %0d, required %0d", acc_hold, DP);
    end
    if (first_after != 13) begin
      fails++; $display("FAIL bp_resume got %0d, required 13", first_after);
    end
    wait_drain();
  endtask

  task automatic test_fault();
    chk_lat = 1;
    do_req(0, 32'h8, 4'hF, 32'hCAFEF00D);
    do_req(1, 32'h4, 4'h0, 32'h0);
    tests++;
    if (last_ce !== 4'b0010) begin
      fails++; $display("FAIL fault_ok_ce got %b, required 0010", last_ce);
    end
    do_req(1, 32'h4000, 4'h0, 32'h0);
    tests++;
    if (last_ce !== 4'b0000) begin
      fails++; $display("FAIL fault_ce got %b, required 0000", last_ce);
    end
    do_req(0, 32'hFFFFFFFC, 4'hF, 32'h12345678);
    tests++;
    if (last_ce !== 4'b0000) begin
      fails++; $display("FAIL fault_hi_ce got %b, required 0000", last_ce);
    end
    do_req(1, 32'h8, 4'h0, 32'h0);
    chk_lat = 0;
    wait_drain();
  endtask

  task automatic test_reset_flight();
    int seen;
    bus.sram_rsp_rdy = 1'b0;
    do_req(1, 32'h0, 4'h0, 32'h0);
    do_req(1, 32'h4, 4'h0, 32'h0);
    do_req(1, 32'h8, 4'h0, 32'h0);
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    tests++;
    if (bus.sram_req_rdy !== 1'b0) begin
      fails++; $display("FAIL rstf_rdy0 got %b, required 0", bus.sram_req_rdy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.sram_req_rdy !== 1'b0) begin
      fails++; $display("FAIL rstf_rdy1 got %b, required 0", bus.sram_req_rdy);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (bus.sram_req_rdy !== 1'b1) begin
      fails++; $display("FAIL rstf_rdy2 got %b, required 1", bus.sram_req_rdy);
    end
    @(posedge clk); #1;
    bus.sram_rsp_rdy = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.sram_rsp_vld) seen++;
      @(posedge clk); #1;
    end
    tests++;
    if (seen != 0) begin
      fails++; $display("FAIL rstf_stale got %0d responses, required 0", seen);
    end
  endtask

  task automatic test_dly0();
    bus0.sram_req_vld  = 1'b1;
    bus0.sram_req_read = 1'b0;
    bus0.sram_req_addr = 32'h10;
    bus0.sram_req_mask = 4'hF;
    bus0.sram_req_data = 32'hDEADBEEF;
    @(negedge clk);
    tests++;
    if (bus0.sram_req_rdy !== 1'b1) begin
      fails++; $display("FAIL d0_rdy got %b, required 1", bus0.sram_req_rdy);
    end
    @(posedge clk); #1;
    bus0.sram_req_read = 1'b1;
    bus0.sram_req_mask = 4'h0;
    bus0.sram_req_data = 32'h0;
    @(negedge clk);
    tests++;
    if (bus0.sram_rsp_vld !== 1'b1 || bus0.sram_rsp_excp !== 2'b00 || bus0.sram_rsp_data !== 32'h0
        || bus0.sram_req_rdy !== 1'b1) begin
      fails++;
      $display("FAIL d0_wr_rsp got vld=%b excp=%b data=%h rdy=%b, required vld=1 excp=00 data=0 rdy=1",
               bus0.sram_rsp_vld, bus0.sram_rsp_excp, bus0.sram_rsp_data, bus0.sram_req_rdy);
    end
    @(posedge clk); #1;
    bus0.sram_req_vld = 1'b0;
    @(negedge clk);
    tests++;
    if (bus0.sram_rsp_vld !== 1'b1 || bus0.sram_rsp_excp !== 2'b00
        || bus0.sram_rsp_data !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL d0_rd_rsp got vld=%b excp=%b data=%h, required vld=1 excp=00 data=deadbeef",
               bus0.sram_rsp_vld, bus0.sram_rsp_excp, bus0.sram_rsp_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (bus0.sram_rsp_vld !== 1'b0) begin
      fails++; $display("FAIL d0_idle got vld=%b, required 0", bus0.sram_rsp_vld);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    bus.sram_req_vld   = 1'b0;
    bus.sram_req_read  = 1'b0;
    bus.sram_req_addr  = '0;
    bus.sram_req_mask  = '0;
    bus.sram_req_data  = '0;
    bus.sram_rsp_rdy   = 1'b1;
    bus0.sram_req_vld  = 1'b0;
    bus0.sram_req_read = 1'b0;
    bus0.sram_req_addr = '0;
    bus0.sram_req_mask = '0;
    bus0.sram_req_data = '0;
    bus0.sram_rsp_rdy  = 1'b1;

    test_reset();
    test_basic();
    test_mask();
    test_stream();
    test_backpressure();
    test_fault();
    test_reset_flight();
    test_dly0();

    tests++;
    if (sbq.size() != 0) begin
      fails++; $display("FAIL final_queue got %0d pending, required 0", sbq.size());
    end
    tests++;
    if (ovf != 0) begin
      fails++; $display("FAIL fifo_overflow got %0d events, required 0", ovf);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
